cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter ROB_W, default 4, ROB index width.
REQ-002 Parameter DEPTH, default 4, per-source queue depth; power of two, >= 2.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rdy  input  1  global enable; low = freeze all state.
REQ-006 flush  input  1  misprediction clear; discards all pending results.
REQ-007 alu_valid  input  1  ALU result present this cycle.
REQ-008 alu_rob_id  input  ROB_W  ROB tag of ALU result.
REQ-009 alu_value  input  32  ALU result value.
REQ-010 lsb_valid  input  1  LSB result present this cycle.
REQ-011 lsb_rob_id  input  ROB_W  ROB tag of LSB result.
REQ-012 lsb_value  input  32  LSB result value.
REQ-013 alu_almost_full  output  1  ALU queue count >= DEPTH-1; RS stops issuing.
REQ-014 lsb_almost_full  output  1  LSB queue count >= DEPTH-1; LSB stops issuing.
REQ-015 cdb_valid  output  1  broadcast valid, registered.
REQ-016 cdb_rob_id  output  ROB_W  broadcast tag, registered.
REQ-017 cdb_value  output  32  broadcast value, registered.
REQ-018 cdb_src  output  1  source of broadcast: 0 ALU, 1 LSB, registered.
REQ-019 overflow  output  1  sticky: a push was dropped on a full queue.

Function
REQ-020 Two independent circular FIFOs (ALU, LSB), DEPTH entries each, head/tail pointers wrap modulo DEPTH, count 0..DEPTH (ROB_W-independent width log2(DEPTH)+1).
REQ-021 Push: when rdy && !flush && src_valid, {rob_id,value} written at tail; tail+1 mod DEPTH; count+1.
REQ-022 Grant decision each rdy cycle from queue state before the edge only (no bypass of same-cycle inputs).
REQ-023 Only one queue non-empty -> grant it.
REQ-024 Both non-empty -> grant the source NOT granted last (round-robin); last_grant register updated on every grant.
REQ-025 Grant pops that queue head at the edge and registers it onto cdb_* with cdb_valid=1, cdb_src set.
REQ-026 No grant (both empty) -> cdb_valid=0 next cycle; cdb_rob_id/cdb_value/cdb_src hold previous values.
REQ-027 Latency: uncontended result pushed at edge N appears on cdb_valid after edge N+1.
REQ-028 Simultaneous push and pop on same queue: count unchanged; accepted even when count==DEPTH.
REQ-029 Push with count==DEPTH and no pop on that queue: dropped, queue unchanged, overflow<=1 (sticky until rst).
REQ-030 almost_full outputs combinational from current count.
REQ-031 flush (with rdy): both queues emptied (head=tail=0, count=0), same-cycle pushes discarded, cdb_valid<=0, last_grant unchanged, overflow unchanged.
REQ-032 rdy low: no pointer, count, output or last_grant change; inputs ignored, no overflow set.
REQ-033 Each queued result broadcast exactly once, in per-source FIFO order.

Reset
REQ-034 rst (sampled at edge, priority over rdy and flush): queues empty, cdb_valid=0, cdb_rob_id=0, cdb_value=0, cdb_src=0, overflow=0, last_grant=LSB (ALU wins first tie).
REQ-035 rst mid-operation discards all queued results; no broadcast in the cycle after rst.

Verification
REQ-036 Single ALU push rob_id=3, value=0x12345678 at edge 1 -> edge 2: cdb_valid=1, rob_id=3, value=0x12345678, cdb_src=0; edge 3: cdb_valid=0.
REQ-037 ALU {1,0xA},{2,0xB} and LSB {5,0xC},{6,0xD} pushed together over 2 cycles -> broadcasts in order tags 1,5,2,6 on consecutive cycles.
REQ-038 Five LSB pushes on consecutive cycles with ALU queue kept non-empty and last_grant=LSB (DEPTH=4) -> lsb_almost_full at count 3, no drop (pops interleave), overflow stays 0; with rdy toggled to stall pops, 5th push -> overflow=1.
REQ-039 Queues holding 3 entries each, flush asserted with alu_valid=1 -> next cycle cdb_valid=0, both counts 0, flushed entries never appear on cdb.
REQ-040 rdy=0 for 3 cycles with both queues non-empty -> cdb outputs and counts frozen; on rdy=1 arbitration resumes with same round-robin order.
REQ-041 rst asserted with 2 entries queued and cdb_valid=1 -> next cycle all outputs zero, subsequent idle cycles cdb_valid=0.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Result/broadcast bundle between the execution units and the CDB arbiter.
// The master side is the execution units plus the CDB consumers; the slave side is the arbiter.
interface cdb_arbiter_if #(
    parameter int ROB_W = 4
);
    logic             aluValid;
    logic [ROB_W-1:0] aluRobId;
    logic [31:0]      aluValue;
    logic             lsbValid;
    logic [ROB_W-1:0] lsbRobId;
    logic [31:0]      lsbValue;
    logic             aluAlmostFull;
    logic             lsbAlmostFull;
    logic             cdbValid;
    logic [ROB_W-1:0] cdbRobId;
    logic [31:0]      cdbValue;
    logic             cdbSrc;
    logic             overflow;

    modport master (
        output aluValid, aluRobId, aluValue,
        output lsbValid, lsbRobId, lsbValue,
        input  aluAlmostFull, lsbAlmostFull,
        input  cdbValid, cdbRobId, cdbValue, cdbSrc, overflow
    );

    modport slave (
        input  aluValid, aluRobId, aluValue,
        input  lsbValid, lsbRobId, lsbValue,
        output aluAlmostFull, lsbAlmostFull,
        output cdbValid, cdbRobId, cdbValue, cdbSrc, overflow
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: queues ALU and LSB results in per-source FIFOs and
// broadcasts one per cycle, round-robin when both sources have work pending.
module cdb_arbiter #(
    parameter int ROB_W = 4,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_rdy,
    input  logic         i_flush,
    cdb_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_t;

    logic [ROB_W-1:0] r_aluRob [DEPTH];
    logic [31:0]      r_aluVal [DEPTH];
    logic [PW-1:0]    r_aluHead;
    logic [PW-1:0]    r_aluTail;
    logic [CW-1:0]    r_aluCount;

    logic [ROB_W-1:0] r_lsbRob [DEPTH];
    logic [31:0]      r_lsbVal [DEPTH];
    logic [PW-1:0]    r_lsbHead;
    logic [PW-1:0]    r_lsbTail;
    logic [CW-1:0]    r_lsbCount;

    src_t             r_lastGrant;
    logic             r_cdbValid;
    logic [ROB_W-1:0] r_cdbRobId;
    logic [31:0]      r_cdbValue;
    src_t             r_cdbSrc;
    logic             r_overflow;

    logic w_active;
    logic w_aluEmpty;
    logic w_lsbEmpty;
    logic w_aluFull;
    logic w_lsbFull;
    logic w_grantAlu;
    logic w_grantLsb;
    logic w_aluPush;
    logic w_lsbPush;
    logic w_aluDrop;
    logic w_lsbDrop;

    assign w_active   = i_rdy && !i_flush;
    assign w_aluEmpty = (r_aluCount == '0);
    assign w_lsbEmpty = (r_lsbCount == '0);
    assign w_aluFull  = (r_aluCount == CW'(DEPTH));
    assign w_lsbFull  = (r_lsbCount == CW'(DEPTH));

    // Grants look only at queue state before the edge; same-cycle inputs never bypass.
    assign w_grantAlu = w_active && !w_aluEmpty && (w_lsbEmpty || r_lastGrant == SRC_LSB);
    assign w_grantLsb = w_active && !w_lsbEmpty && (w_aluEmpty || r_lastGrant == SRC_ALU);

    // A full queue still accepts a push when its head is popped in the same cycle.
    assign w_aluPush = w_active && bus.aluValid && (!w_aluFull || w_grantAlu);
    assign w_lsbPush = w_active && bus.lsbValid && (!w_lsbFull || w_grantLsb);
    assign w_aluDrop = w_active && bus.aluValid && w_aluFull && !w_grantAlu;
    assign w_lsbDrop = w_active && bus.lsbValid && w_lsbFull && !w_grantLsb;

    always_ff @(posedge i_clk) begin
        if (w_aluPush) begin
            r_aluRob[r_aluTail] <= bus.aluRobId;
            r_aluVal[r_aluTail] <= bus.aluValue;
        end
        if (w_lsbPush) begin
            r_lsbRob[r_lsbTail] <= bus.lsbRobId;
            r_lsbVal[r_lsbTail] <= bus.lsbValue;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_aluHead   <= '0;
            r_aluTail   <= '0;
            r_aluCount  <= '0;
            r_lsbHead   <= '0;
            r_lsbTail   <= '0;
            r_lsbCount  <= '0;
            r_lastGrant <= SRC_LSB;
            r_cdbValid  <= 1'b0;
            r_cdbRobId  <= '0;
            r_cdbValue  <= '0;
            r_cdbSrc    <= SRC_ALU;
            r_overflow  <= 1'b0;
        end else if (i_rdy) begin
            if (i_flush) begin
                r_aluHead  <= '0;
                r_aluTail  <= '0;
                r_aluCount <= '0;
                r_lsbHead  <= '0;
                r_lsbTail  <= '0;
                r_lsbCount <= '0;
                r_cdbValid <= 1'b0;
            end else begin
                if (w_aluPush) r_aluTail <= r_aluTail + PW'(1);
                if (w_lsbPush) r_lsbTail <= r_lsbTail + PW'(1);
                if (w_grantAlu) r_aluHead <= r_aluHead + PW'(1);
                if (w_grantLsb) r_lsbHead <= r_lsbHead + PW'(1);

                case ({w_aluPush, w_grantAlu})
                    2'b10:   r_aluCount <= r_aluCount + CW'(1);
                    2'b01:   r_aluCount <= r_aluCount - CW'(1);
                    default: r_aluCount <= r_aluCount;
                endcase
                case ({w_lsbPush, w_grantLsb})
                    2'b10:   r_lsbCount <= r_lsbCount + CW'(1);
                    2'b01:   r_lsbCount <= r_lsbCount - CW'(1);
                    default: r_lsbCount <= r_lsbCount;
                endcase

                // Without a grant only the valid drops; tag, value and source hold.
                if (w_grantAlu) begin
                    r_cdbValid  <= 1'b1;
                    r_cdbRobId  <= r_aluRob[r_aluHead];
                    r_cdbValue  <= r_aluVal[r_aluHead];
                    r_cdbSrc    <= SRC_ALU;
                    r_lastGrant <= SRC_ALU;
                end else if (w_grantLsb) begin
                    r_cdbValid  <= 1'b1;
                    r_cdbRobId  <= r_lsbRob[r_lsbHead];
                    r_cdbValue  <= r_lsbVal[r_lsbHead];
                    r_cdbSrc    <= SRC_LSB;
                    r_lastGrant <= SRC_LSB;
                end else begin
                    r_cdbValid  <= 1'b0;
                end

                if (w_aluDrop || w_lsbDrop) r_overflow <= 1'b1;
            end
        end
    end

    assign bus.aluAlmostFull = (r_aluCount >= CW'(DEPTH - 1));
    assign bus.lsbAlmostFull = (r_lsbCount >= CW'(DEPTH - 1));
    assign bus.cdbValid      = r_cdbValid;
    assign bus.cdbRobId      = r_cdbRobId;
    assign bus.cdbValue      = r_cdbValue;
    assign bus.cdbSrc        = r_cdbSrc;
    assign bus.overflow      = r_overflow;
endmodule
